// File: rtl/pool_ctrl_pkg.sv
// Shared constants for the 2x2 max-pool controller: bus widths, DRAM region map,
// one-hot state encoding and the packed feature-map address layout.
package pool_ctrl_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned ADDR_WIDTH = 18;

  localparam logic [ADDR_WIDTH-1:0] PARAM_BASE = 18'd0;
  localparam logic [ADDR_WIDTH-1:0] WTS_BASE   = 18'd16384;
  localparam logic [ADDR_WIDTH-1:0] IFMAP_BASE = 18'd65536;
  localparam logic [ADDR_WIDTH-1:0] OFMAP_BASE = 18'd131072;
  localparam logic [ADDR_WIDTH-1:0] POOL_BASE  = 18'd196608;

  localparam int unsigned CHNL_W = 4;
  localparam int unsigned Y_W    = 5;
  localparam int unsigned X_W    = 5;

  localparam int unsigned IDX_IDLE = 0;
  localparam int unsigned IDX_RD   = 1;
  localparam int unsigned IDX_CMP  = 2;
  localparam int unsigned IDX_WR   = 3;
  localparam int unsigned IDX_DONE = 4;

  typedef enum logic [4:0] {
    StIdle = 5'b00001,
    StRd   = 5'b00010,
    StCmp  = 5'b00100,
    StWr   = 5'b01000,
    StDone = 5'b10000
  } state_e;

  // Word address inside a region: {4'd0, chnl, y, x}, fields already truncated.
  function automatic logic [ADDR_WIDTH-1:0] fmap_addr(input logic [ADDR_WIDTH-1:0] base,
                                                     input logic [CHNL_W-1:0]     chnl,
                                                     input logic [Y_W-1:0]        y,
                                                     input logic [X_W-1:0]        x);
    return base + {4'd0, chnl, y, x};
  endfunction

endpackage

// File: rtl/pool_ctrl_if.sv
// DRAM port bundle of the pooling controller: one read channel (data returns one cycle
// after the address) and one write channel.
interface pool_ctrl_if;
  import pool_ctrl_pkg::*;

  logic [ADDR_WIDTH-1:0] addr_in;
  logic                  dram_en_rd;
  logic [DATA_WIDTH-1:0] data_in;
  logic [ADDR_WIDTH-1:0] addr_out;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  dram_en_wr;

  modport master (
    output addr_in, dram_en_rd, addr_out, data_out, dram_en_wr,
    input  data_in
  );

  modport slave (
    input  addr_in, dram_en_rd, addr_out, data_out, dram_en_wr,
    output data_in
  );

endinterface

// File: rtl/pool_max_unit.sv
// Running signed maximum over one 2x2 window. Define POOL_RELU_EN to clamp the
// first word of each window at zero (fused ReLU); timing is identical either way.
module pool_max_unit
  import pool_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  rd_phase,
  input  logic                  cmp_phase,
  input  logic [1:0]            win,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] acc
);

  logic [DATA_WIDTH-1:0] acc_q, acc_d, load_val;
  logic                  load, fold;

  always_comb begin
    // Read k returns during the cycle of read k+1, so word 0 lands while win==1.
    load = rd_phase && (win == 2'd1);
    fold = (rd_phase && win[1]) || cmp_phase;
`ifdef POOL_RELU_EN
    load_val = data_in[DATA_WIDTH-1] ? '0 : data_in;
`else
    load_val = data_in;
`endif
    acc_d = acc_q;
    if (load) begin
      acc_d = load_val;
    end else if (fold && ($signed(data_in) > $signed(acc_q))) begin
      acc_d = data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/pool_ctrl.sv
// 2x2 stride-2 signed max pooling from the OFMAP region into the POOL region, 6 cycles
// per output word. POOL_RELU_EN (see pool_max_unit) selects the fused-ReLU build.
module pool_ctrl
  import pool_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        srst,
  input  logic        enable,
  input  logic [4:0]  num_chnl,
  input  logic [5:0]  fmap_height,
  input  logic [5:0]  fmap_width,
  output logic        done,
  pool_ctrl_if.master dram
);

  state_e                state_q, state_d;
  logic [1:0]            win_q, win_d;
  logic [4:0]            px_q, px_d, py_q, py_d, chnl_q, chnl_d;
  logic [4:0]            n_chnl_q, n_chnl_d, out_h_q, out_h_d, out_w_q, out_w_d;
  logic [DATA_WIDTH-1:0] acc;

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q  <= StIdle;
      win_q    <= '0;
      px_q     <= '0;
      py_q     <= '0;
      chnl_q   <= '0;
      n_chnl_q <= '0;
      out_h_q  <= '0;
      out_w_q  <= '0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      px_q     <= px_d;
      py_q     <= py_d;
      chnl_q   <= chnl_d;
      n_chnl_q <= n_chnl_d;
      out_h_q  <= out_h_d;
      out_w_q  <= out_w_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    px_d     = px_q;
    py_d     = py_q;
    chnl_d   = chnl_q;
    n_chnl_d = n_chnl_q;
    out_h_d  = out_h_q;
    out_w_d  = out_w_q;
    unique case (state_q)
      StIdle: begin
        if (enable) begin
          n_chnl_d = num_chnl;
          out_h_d  = fmap_height[5:1];
          out_w_d  = fmap_width[5:1];
          win_d    = '0;
          px_d     = '0;
          py_d     = '0;
          chnl_d   = '0;
          if (num_chnl == 5'd0 || fmap_height < 6'd2 || fmap_width < 6'd2) begin
            state_d = StDone;
          end else begin
            state_d = StRd;
          end
        end
      end
      StRd: begin
        win_d = win_q + 2'd1;
        if (win_q == 2'd3) state_d = StCmp;
      end
      StCmp: state_d = StWr;
      StWr: begin
        state_d = StRd;
        if (px_q == out_w_q - 5'd1) begin
          px_d = '0;
          if (py_q == out_h_q - 5'd1) begin
            py_d = '0;
            if (chnl_q == n_chnl_q - 5'd1) begin
              chnl_d  = '0;
              state_d = StDone;
            end else begin
              chnl_d = chnl_q + 5'd1;
            end
          end else begin
            py_d = py_q + 5'd1;
          end
        end else begin
          px_d = px_q + 5'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  pool_max_unit u_max (
    .clk       (clk),
    .srst      (srst),
    .rd_phase  (state_q[IDX_RD]),
    .cmp_phase (state_q[IDX_CMP]),
    .win       (win_q),
    .data_in   (dram.data_in),
    .acc       (acc)
  );

  // Window row/col = 2*p + d; the low bit of win is dx, the high bit dy.
  always_comb begin
    dram.dram_en_rd = state_q[IDX_RD];
    dram.addr_in    = '0;
    if (state_q[IDX_RD]) begin
      dram.addr_in = fmap_addr(OFMAP_BASE, chnl_q[3:0], {py_q[3:0], win_q[1]},
                               {px_q[3:0], win_q[0]});
    end
    dram.dram_en_wr = state_q[IDX_WR];
    dram.addr_out   = '0;
    dram.data_out   = '0;
    if (state_q[IDX_WR]) begin
      dram.addr_out = fmap_addr(POOL_BASE, chnl_q[3:0], py_q, px_q);
      dram.data_out = acc;
    end
    done = state_q[IDX_DONE];
  end

endmodule

// File: tb/tb_pool_ctrl.sv
// Directed bench for pool_ctrl: DRAM model with one-cycle read latency, write log and
// hand-computed expected pooled words, addresses and cycle timing.
module tb_pool_ctrl;
  import pool_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       srst, enable, done;
  logic [4:0] num_chnl;
  logic [5:0] fmap_height, fmap_width;

  pool_ctrl_if dram_bus ();

  pool_ctrl u_dut (
    .clk         (clk),
    .srst        (srst),
    .enable      (enable),
    .num_chnl    (num_chnl),
    .fmap_height (fmap_height),
    .fmap_width  (fmap_width),
    .done        (done),
    .dram        (dram_bus)
  );

  always #5 clk = ~clk;

`ifdef POOL_RELU_EN
  localparam longint ExpNeg = 0;
`else
  localparam longint ExpNeg = -3;
`endif

  logic [DATA_WIDTH-1:0] mem [int];
  logic [ADDR_WIDTH-1:0] wa_q [$];
  logic [DATA_WIDTH-1:0] wd_q [$];
  int cyc = 0;
  int rd_count, done_count, first_rd, first_addr, done_cyc, max_rd_x, max_rd_y, en_cyc;
  int n_checks = 0;
  int n_err = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (dram_bus.dram_en_rd) begin
      dram_bus.data_in <= mem.exists(int'(dram_bus.addr_in)) ? mem[int'(dram_bus.addr_in)] : '0;
    end
  end

  always @(negedge clk) begin
    if (dram_bus.dram_en_rd) begin
      if (rd_count == 0) begin
        first_rd   = cyc;
        first_addr = int'(dram_bus.addr_in);
      end
      rd_count = rd_count + 1;
      if (int'(dram_bus.addr_in[4:0]) > max_rd_x) max_rd_x = int'(dram_bus.addr_in[4:0]);
      if (int'(dram_bus.addr_in[9:5]) > max_rd_y) max_rd_y = int'(dram_bus.addr_in[9:5]);
    end
    if (dram_bus.dram_en_wr) begin
      wa_q.push_back(dram_bus.addr_out);
      wd_q.push_back(dram_bus.data_out);
    end
    if (done) begin
      if (done_count == 0) done_cyc = cyc;
      done_count = done_count + 1;
    end
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_wr(input string tag, input int idx, input longint ea, input longint ed);
    if (idx < wa_q.size()) begin
      check({tag, "_addr"}, longint'(wa_q[idx]), ea);
      check({tag, "_data"}, longint'($signed(wd_q[idx])), ed);
    end else begin
      check({tag, "_missing"}, longint'(wa_q.size()), longint'(idx + 1));
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_addr_in"}, longint'(dram_bus.addr_in), 0);
    check({tag, "_en_rd"}, longint'(dram_bus.dram_en_rd), 0);
    check({tag, "_addr_out"}, longint'(dram_bus.addr_out), 0);
    check({tag, "_data_out"}, longint'(dram_bus.data_out), 0);
    check({tag, "_en_wr"}, longint'(dram_bus.dram_en_wr), 0);
    check({tag, "_done"}, longint'(done), 0);
  endtask

  task automatic put(input int c, input int y, input int x, input longint v);
    mem[int'(OFMAP_BASE) + (c << 10) + (y << 5) + x] = DATA_WIDTH'(v);
  endtask

  task automatic fill_4x4();
    mem.delete();
    for (int y = 0; y < 4; y++) for (int x = 0; x < 4; x++) put(0, y, x, y * 4 + x);
  endtask

  task automatic clear_log();
    rd_count = 0; done_count = 0; first_rd = -1; first_addr = -1; done_cyc = -1;
    max_rd_x = -1; max_rd_y = -1;
    wa_q.delete();
    wd_q.delete();
  endtask

  task automatic start(input logic [4:0] n, input logic [5:0] h, input logic [5:0] w);
    @(negedge clk);
    num_chnl = n; fmap_height = h; fmap_width = w; enable = 1'b1; en_cyc = cyc;
    @(negedge clk);
    enable = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int i = 0;
    while (done_count == 0 && i < budget) begin
      @(posedge clk);
      i++;
    end
    if (done_count == 0) check("done_timeout", 0, 1);
    repeat (4) @(posedge clk);
  endtask

  localparam longint Pool = longint'(POOL_BASE);
  int exp_5x5 [8] = '{6, 8, 16, 18, 106, 108, 116, 118};

  initial begin
    srst = 1'b1; enable = 1'b0; num_chnl = '0; fmap_height = '0; fmap_width = '0;
    clear_log();
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    srst = 1'b0;

    // 4x4 ramp, one channel
    fill_4x4();
    clear_log();
    start(5'd1, 6'd4, 6'd4);
    wait_done(300);
    check("t1_wr_count", wa_q.size(), 4);
    check_wr("t1_w0", 0, Pool + 0, 5);
    check_wr("t1_w1", 1, Pool + 1, 7);
    check_wr("t1_w2", 2, Pool + 32, 13);
    check_wr("t1_w3", 3, Pool + 33, 15);
    check("t1_rd_count", rd_count, 16);
    check("t1_first_rd_lat", first_rd - en_cyc, 1);
    check("t1_done_on_cycle", done_cyc - first_rd + 1, 25);
    check("t1_done_pulses", done_count, 1);

    // Signed compare: all-negative window and a mixed-sign window
    mem.delete();
    put(0, 0, 0, -9); put(0, 0, 1, -3); put(0, 1, 0, -7); put(0, 1, 1, -5);
    put(0, 0, 2, -1); put(0, 0, 3, 5);  put(0, 1, 2, -100); put(0, 1, 3, 3);
    clear_log();
    start(5'd1, 6'd2, 6'd4);
    wait_done(200);
    check("t2_wr_count", wa_q.size(), 2);
    check_wr("t2_neg", 0, Pool + 0, ExpNeg);
    check_wr("t2_mix", 1, Pool + 1, 5);

    // 5x5, two channels: odd row/column dropped
    mem.delete();
    for (int c = 0; c < 2; c++)
      for (int y = 0; y < 5; y++) for (int x = 0; x < 5; x++) put(c, y, x, c * 100 + y * 5 + x);
    clear_log();
    start(5'd2, 6'd5, 6'd5);
    wait_done(400);
    check("t3_wr_count", wa_q.size(), 8);
    for (int i = 0; i < 8; i++)
      check_wr($sformatf("t3_w%0d", i), i, Pool + (i / 4) * 1024 + ((i / 2) % 2) * 32 + (i % 2),
               exp_5x5[i]);
    check("t3_max_x", max_rd_x, 3);
    check("t3_max_y", max_rd_y, 3);
    check("t3_rd_count", rd_count, 32);
    check("t3_done_lat", done_cyc - first_rd, 48);

    // Degenerate sizes
    clear_log();
    start(5'd1, 6'd4, 6'd1);
    wait_done(50);
    check("t4w_rd", rd_count, 0);
    check("t4w_wr", wa_q.size(), 0);
    check("t4w_done_lat", done_cyc - en_cyc, 1);
    clear_log();
    start(5'd0, 6'd4, 6'd4);
    wait_done(50);
    check("t4c_rd", rd_count, 0);
    check("t4c_wr", wa_q.size(), 0);
    check("t4c_done_lat", done_cyc - en_cyc, 1);

    // Reset on the 3rd RD cycle of window 2, then a clean restart
    fill_4x4();
    clear_log();
    start(5'd1, 6'd4, 6'd4);
    while (cyc < en_cyc + 15) @(negedge clk);
    check("t5_pre_en_rd", longint'(dram_bus.dram_en_rd), 1);
    check("t5_pre_addr", longint'(dram_bus.addr_in), longint'(OFMAP_BASE) + 96);
    srst = 1'b1;
    @(negedge clk);
    check_idle_outputs("t5_post");
    srst = 1'b0;
    repeat (40) @(posedge clk);
    check("t5_wr_count", wa_q.size(), 2);
    check("t5_no_done", done_count, 0);
    clear_log();
    start(5'd1, 6'd4, 6'd4);
    wait_done(300);
    check("t5r_first_addr", first_addr, longint'(OFMAP_BASE));
    check("t5r_first_rd_lat", first_rd - en_cyc, 1);
    check_wr("t5r_w0", 0, Pool + 0, 5);
    check_wr("t5r_w3", 3, Pool + 33, 15);

    // enable pulse while busy must be ignored
    clear_log();
    start(5'd1, 6'd4, 6'd4);
    while (cyc < en_cyc + 3) @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    wait_done(300);
    repeat (20) @(posedge clk);
    check("t6_wr_count", wa_q.size(), 4);
    check("t6_done_on_cycle", done_cyc - first_rd + 1, 25);
    check("t6_done_pulses", done_count, 1);
    check("t6_rd_count", rd_count, 16);
    check_wr("t6_w3", 3, Pool + 33, 15);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
